// File: rtl/uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx_data_sampler
//  Brief   : UART RX front end. It synchronises the serial line, runs the
//            per-bit edge counter and the frame bit counter, and makes a
//            majority-voted bit decision around the centre of each bit.
//            Optional macro UART_RX_SAMPLER_5TAP_EN selects a 5-tap vote.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rx_data_sampler #(
   parameter int SCALER_WIDTH  = 5,
   parameter int BIT_CNT_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_in,
   input  logic [SCALER_WIDTH-1:0]  prescale,
   input  logic                     cnt_en,
   input  logic                     smp_en,
   output logic                     rx_sync,
   output logic [SCALER_WIDTH-1:0]  edge_count,
   output logic [BIT_CNT_WIDTH-1:0] bit_count,
   output logic                     bit_done,
   output logic                     sampled_bit
);

`ifdef UART_RX_SAMPLER_5TAP_EN
   localparam int                      c_TAPS   = 5;
   localparam logic [SCALER_WIDTH-1:0] c_PQ_MIN = SCALER_WIDTH'(8);
`else
   localparam int                      c_TAPS   = 3;
   localparam logic [SCALER_WIDTH-1:0] c_PQ_MIN = SCALER_WIDTH'(4);
`endif
   localparam logic [SCALER_WIDTH-1:0]  c_ONE       = SCALER_WIDTH'(1);
   localparam logic [SCALER_WIDTH-1:0]  c_FIRST_OFS = SCALER_WIDTH'(c_TAPS - 2);
   localparam logic [SCALER_WIDTH-1:0]  c_TAP_CNT   = SCALER_WIDTH'(c_TAPS);
   localparam logic [SCALER_WIDTH-1:0]  c_VOTE_IDX  = SCALER_WIDTH'(c_TAPS - 1);
   localparam logic [BIT_CNT_WIDTH-1:0] c_BIT_MAX   = {BIT_CNT_WIDTH{1'b1}};
   localparam logic [2:0]               c_MAJ_THR   = 3'(c_TAPS / 2 + 1);

   logic                     r_sync_meta;
   logic                     r_sync;
   logic [SCALER_WIDTH-1:0]  r_prescale_q;
   logic [SCALER_WIDTH-1:0]  r_edge_count;
   logic [BIT_CNT_WIDTH-1:0] r_bit_count;
   logic [c_TAPS-1:0]        r_samples;
   logic                     r_sampled_bit;

   logic [SCALER_WIDTH-1:0]  w_pq_even;
   logic [SCALER_WIDTH-1:0]  w_pq_next;
   logic [SCALER_WIDTH-1:0]  w_half;
   logic [SCALER_WIDTH-1:0]  w_last_edge;
   logic [SCALER_WIDTH-1:0]  w_tap_idx;
   logic                     w_in_window;
   logic                     w_vote_now;
   logic                     w_bit_done;
   logic                     w_sample_ok;
   logic [2:0]               w_ones;
   logic                     w_majority;

   assign w_pq_even   = prescale & ~c_ONE;
   assign w_pq_next   = (w_pq_even < c_PQ_MIN) ? c_PQ_MIN : w_pq_even;
   assign w_half      = r_prescale_q >> 1;
   assign w_last_edge = r_prescale_q - c_ONE;
   assign w_bit_done  = cnt_en && (r_edge_count == w_last_edge);

   // Window offset relative to the first tap; edges before it wrap to large values.
   assign w_tap_idx   = r_edge_count - (w_half - c_FIRST_OFS);
   assign w_in_window = (w_tap_idx < c_TAP_CNT);
   assign w_vote_now  = w_in_window && (w_tap_idx == c_VOTE_IDX);
   assign w_sample_ok = smp_en && cnt_en;

   // The last tap is taken straight from the line so the vote lands on the half+1 edge.
   always_comb begin
      w_ones = 3'd0;
      for (int k = 0; k < c_TAPS - 1; k++) begin
         w_ones = w_ones + {2'b00, r_samples[k]};
      end
      w_ones     = w_ones + {2'b00, r_sync};
      w_majority = (w_ones >= c_MAJ_THR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
      end else begin
         r_sync_meta <= rx_in;
         r_sync      <= r_sync_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale_q <= c_PQ_MIN;
         r_edge_count <= '0;
         r_bit_count  <= '0;
      end else if (!cnt_en) begin
         r_prescale_q <= w_pq_next;
         r_edge_count <= '0;
         r_bit_count  <= '0;
      end else if (w_bit_done) begin
         r_edge_count <= '0;
         if (r_bit_count != c_BIT_MAX) begin
            r_bit_count <= r_bit_count + BIT_CNT_WIDTH'(1);
         end
      end else begin
         r_edge_count <= r_edge_count + c_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_samples     <= '1;
         r_sampled_bit <= 1'b1;
      end else if (w_sample_ok && w_in_window) begin
         for (int k = 0; k < c_TAPS; k++) begin
            if (w_tap_idx == SCALER_WIDTH'(k)) begin
               r_samples[k] <= r_sync;
            end
         end
         if (w_vote_now) begin
            r_sampled_bit <= w_majority;
         end
      end
   end

   assign rx_sync     = r_sync;
   assign edge_count  = r_edge_count;
   assign bit_count   = r_bit_count;
   assign bit_done    = w_bit_done;
   assign sampled_bit = r_sampled_bit;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_rx_data_sampler
//  Brief   : Directed bench for uart_rx_data_sampler with a cycle-level
//            reference model of the line delay, bit timing and centre vote.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx_data_sampler;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_in;
   logic [4:0] prescale;
   logic       cnt_en;
   logic       smp_en;
   logic       rx_sync;
   logic [4:0] edge_count;
   logic [3:0] bit_count;
   logic       bit_done;
   logic       sampled_bit;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   uart_rx_data_sampler #(
      .SCALER_WIDTH  (5),
      .BIT_CNT_WIDTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_in       (rx_in),
      .prescale    (prescale),
      .cnt_en      (cnt_en),
      .smp_en      (smp_en),
      .rx_sync     (rx_sync),
      .edge_count  (edge_count),
      .bit_count   (bit_count),
      .bit_done    (bit_done),
      .sampled_bit (sampled_bit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: m_n counts edges since counting began, m_p is the frozen
   // bit period, m_line holds the last two raw line values (oldest first).
   int   m_n = 0;
   int   m_p = 4;
   logic m_line[$] = '{1'b1, 1'b1};
   logic m_samp[0:31];
   logic m_sampled = 1'b1;

   initial foreach (m_samp[i]) m_samp[i] = 1'b1;

   always @(posedge clk) begin : model
      int   cur_e;
      int   h;
      int   pe;
      logic cur_line;
      if (rst) begin
         m_n       = 0;
         m_p       = 4;
         m_line    = '{1'b1, 1'b1};
         m_sampled = 1'b1;
         foreach (m_samp[i]) m_samp[i] = 1'b1;
      end else begin
         cur_e    = m_n % m_p;
         h        = m_p / 2;
         cur_line = m_line[0];
         if (cnt_en && smp_en && cur_e >= h - 1 && cur_e <= h + 1) begin
            m_samp[cur_e] = cur_line;
            if (cur_e == h + 1) begin
               m_sampled = (m_samp[h-1] & m_samp[h]) | (m_samp[h-1] & cur_line) |
                           (m_samp[h] & cur_line);
            end
         end
         if (cnt_en) begin
            m_n++;
         end else begin
            m_n = 0;
            pe  = int'(prescale) - (int'(prescale) % 2);
            m_p = (pe < 4) ? 4 : pe;
         end
         m_line.push_back(rx_in);
         void'(m_line.pop_front());
      end
   end

   always @(negedge clk) begin : compare
      int e_edge;
      int e_bits;
      if (chk_en) begin
         #1;
         e_edge = m_n % m_p;
         e_bits = (m_n / m_p > 15) ? 15 : m_n / m_p;
         chk("model_rx_sync", rx_sync, m_line[0]);
         chk("model_edge_count", edge_count, e_edge);
         chk("model_bit_count", bit_count, e_bits);
         chk("model_bit_done", bit_done, int'(cnt_en && (e_edge == m_p - 1)));
         chk("model_sampled_bit", sampled_bit, m_sampled);
      end
   end

   initial begin
      logic [7:0] pattern;
      pattern  = 8'b1011_0010;
      rst      = 1'b1;
      rx_in    = 1'b0;
      prescale = 5'd8;
      cnt_en   = 1'b0;
      smp_en   = 1'b0;
      step(2);
      chk("rst_rx_sync", rx_sync, 1);
      chk("rst_sampled_bit", sampled_bit, 1);
      chk("rst_edge_count", edge_count, 0);
      chk("rst_bit_count", bit_count, 0);
      chk_en = 1'b1;
      rst    = 1'b0;
      step(1);

      // Steady low line at prescale 8
      cnt_en = 1'b1;
      smp_en = 1'b1;
      step(6);
      chk("p8_edge6", edge_count, 6);
      chk("p8_sampled_low", sampled_bit, 0);
      step(1);
      chk("p8_edge7", edge_count, 7);
      chk("p8_bit_done", bit_done, 1);
      step(1);
      chk("p8_wrap_edge", edge_count, 0);
      chk("p8_bit_count1", bit_count, 1);

      // Single glitched sample at edge 4 is outvoted
      step(2);
      rx_in = 1'b1;
      step(1);
      rx_in = 1'b0;
      step(3);
      chk("glitch1_sampled", sampled_bit, 0);

      // Two of three samples high wins the vote
      step(4);
      rx_in = 1'b1;
      step(2);
      rx_in = 1'b0;
      step(2);
      chk("glitch2_sampled", sampled_bit, 1);

      // Bit-aligned data pattern, MSB first
      step(2);
      chk("align_edge0", edge_count, 0);
      for (int i = 7; i >= 0; i--) begin
         rx_in = pattern[i];
         step(8);
      end
      chk("pattern_last_bit", sampled_bit, 0);

      // smp_en low: vote holds although the line changed
      smp_en = 1'b0;
      rx_in  = 1'b1;
      step(16);
      chk("smp_hold", sampled_bit, 0);

      // cnt_en falls mid-bit before the vote
      smp_en = 1'b1;
      step(3);
      cnt_en = 1'b0;
      step(1);
      chk("cnt_fall_edge", edge_count, 0);
      chk("cnt_fall_bits", bit_count, 0);
      chk("cnt_fall_sampled", sampled_bit, 0);

      // Prescale 16: count to 11, then saturate at 15
      prescale = 5'd16;
      rx_in    = 1'b0;
      step(1);
      cnt_en = 1'b1;
      step(176);
      chk("p16_bits11", bit_count, 11);
      chk("p16_edge0", edge_count, 0);
      step(144);
      chk("p16_sat20", bit_count, 15);
      step(16);
      chk("p16_sat21", bit_count, 15);

      // Prescale change mid-frame is ignored until cnt_en drops
      prescale = 5'd8;
      step(15);
      chk("frozen_edge15", edge_count, 15);
      chk("frozen_done", bit_done, 1);
      step(1);
      chk("frozen_wrap", edge_count, 0);
      cnt_en = 1'b0;
      step(1);
      cnt_en = 1'b1;
      step(7);
      chk("new8_edge7", edge_count, 7);
      chk("new8_done", bit_done, 1);
      step(1);
      chk("new8_bits1", bit_count, 1);

      // Reset mid-frame, then clamped prescale
      step(5);
      chk("pre_rst_edge5", edge_count, 5);
      chk("pre_rst_sampled", sampled_bit, 0);
      rst      = 1'b1;
      prescale = 5'd3;
      step(1);
      chk("mid_rst_rx_sync", rx_sync, 1);
      chk("mid_rst_sampled", sampled_bit, 1);
      chk("mid_rst_edge", edge_count, 0);
      chk("mid_rst_bits", bit_count, 0);
      rst    = 1'b0;
      cnt_en = 1'b0;
      step(1);
      cnt_en   = 1'b1;
      prescale = 5'd12;
      step(3);
      chk("p4_edge3", edge_count, 3);
      chk("p4_done", bit_done, 1);
      step(1);
      chk("p4_bits1", bit_count, 1);
      step(9);
      chk("p4_bits3", bit_count, 3);
      chk("p4_edge1", edge_count, 1);

      step(2);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
